// File: rtl/phase_accumulator.sv
// DDS phase accumulator (NCO) with phase-continuous FTW updates
// and a linear per-wrap frequency sweep.
module phase_accumulator #(
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 12,
    parameter int STEP_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [ACC_W-1:0]   ftw_in,
    input  logic               ftw_valid,
    output logic               ftw_ready,
    input  logic [PHASE_W-1:0] phase_off,
    input  logic               sweep_en,
    input  logic [STEP_W-1:0]  sweep_step,
    input  logic [ACC_W-1:0]   sweep_stop,
    output logic [PHASE_W-1:0] phase_out,
    output logic               wrap_pulse,
    output logic               sweep_done
);

    typedef enum logic [1:0] {
        S_RUN,
        S_PEND,
        S_SWEEP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_next;
    logic [ACC_W:0]     acc_sum;
    logic               wrap;
    logic [ACC_W-1:0]   ftw_act;
    logic [ACC_W-1:0]   ftw_act_next;
    logic [ACC_W-1:0]   ftw_pend;
    logic [ACC_W-1:0]   ftw_pend_next;
    logic [ACC_W:0]     sweep_sum;
    logic               done_next;
    logic               hs;
    logic [PHASE_W-1:0] phase_next;

    assign hs = ftw_valid && ftw_ready;

    // Accumulator add; the carry of the widened sum is the wrap event
    always_comb begin
        acc_sum  = {1'b0, acc} + {1'b0, ftw_act};
        acc_next = acc;
        wrap     = 1'b0;
        if (enable) begin
            acc_next = acc_sum[ACC_W-1:0];
            wrap     = acc_sum[ACC_W];
        end
    end

    // Sweep increment kept one bit wider so it never wraps past sweep_stop
    always_comb begin
        sweep_sum = {1'b0, ftw_act}
                  + {{(ACC_W + 1 - STEP_W){1'b0}}, sweep_step};
    end

    // Output phase: top accumulator bits plus offset, modulo 2^PHASE_W
    always_comb begin
        phase_next = acc_next[ACC_W-1 -: PHASE_W] + phase_off;
    end

    // Next-state logic: FTW handoff at wrap and per-wrap sweep stepping
    always_comb begin
        state_next    = state;
        ftw_act_next  = ftw_act;
        ftw_pend_next = ftw_pend;
        done_next     = 1'b0;
        unique case (state)
            S_RUN: begin
                if (hs) begin
                    if (ftw_act == '0) begin
                        ftw_act_next = ftw_in;
                    end else begin
                        ftw_pend_next = ftw_in;
                        state_next    = S_PEND;
                    end
                end else if (sweep_en && (ftw_act < sweep_stop)) begin
                    state_next = S_SWEEP;
                end
            end
            S_PEND: begin
                if (wrap) begin
                    ftw_act_next = ftw_pend;
                    state_next   = S_RUN;
                end
            end
            S_SWEEP: begin
                if (!sweep_en) begin
                    state_next = S_RUN;
                end else if (wrap) begin
                    if (sweep_sum >= {1'b0, sweep_stop}) begin
                        ftw_act_next = sweep_stop;
                        done_next    = 1'b1;
                        state_next   = S_RUN;
                    end else begin
                        ftw_act_next = sweep_sum[ACC_W-1:0];
                    end
                end
            end
            default: begin
                state_next = S_RUN;
            end
        endcase
    end

    // State, accumulator and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_RUN;
            acc        <= '0;
            ftw_act    <= '0;
            ftw_pend   <= '0;
            ftw_ready  <= 1'b1;
            phase_out  <= '0;
            wrap_pulse <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            state      <= state_next;
            acc        <= acc_next;
            ftw_act    <= ftw_act_next;
            ftw_pend   <= ftw_pend_next;
            ftw_ready  <= (state_next == S_RUN);
            phase_out  <= phase_next;
            wrap_pulse <= wrap;
            sweep_done <= done_next;
        end
    end

endmodule

// File: tb/tb_phase_accumulator.sv
// Testbench for phase_accumulator: fixed vector table, hand-built
// sweep/pause/reset sequences and randomized run against a model.
module tb_phase_accumulator;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] ftw_in;
    logic        ftw_valid;
    logic        ftw_ready;
    logic [11:0] phase_off;
    logic        sweep_en;
    logic [15:0] sweep_step;
    logic [31:0] sweep_stop;
    logic [11:0] phase_out;
    logic        wrap_pulse;
    logic        sweep_done;

    int n_pass;
    int n_total;

    phase_accumulator dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .ftw_in     (ftw_in),
        .ftw_valid  (ftw_valid),
        .ftw_ready  (ftw_ready),
        .phase_off  (phase_off),
        .sweep_en   (sweep_en),
        .sweep_step (sweep_step),
        .sweep_stop (sweep_stop),
        .phase_out  (phase_out),
        .wrap_pulse (wrap_pulse),
        .sweep_done (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: arithmetic on wide integers, mode as plain int
    localparam int M_RUN   = 0;
    localparam int M_PEND  = 1;
    localparam int M_SWEEP = 2;
    localparam longint unsigned TWO32 = 64'h1_0000_0000;

    longint unsigned m_acc;
    longint unsigned m_ftw;
    longint unsigned m_pend;
    int              m_mode;
    longint unsigned m_phase;
    bit              m_wrap;
    bit              m_done;
    bit              m_ready;

    task automatic model_step();
        longint unsigned s;
        longint unsigned a;
        longint unsigned t;
        bit w;
        if (rst) begin
            m_acc = 0; m_ftw = 0; m_pend = 0; m_mode = M_RUN;
            m_phase = 0; m_wrap = 0; m_done = 0; m_ready = 1;
            return;
        end
        s = m_acc + m_ftw;
        w = enable && (s >= TWO32);
        a = enable ? (s % TWO32) : m_acc;
        m_phase = ((a >> 20) + longint'(phase_off)) % 4096;
        m_wrap = w;
        m_done = 0;
        if (m_mode == M_RUN) begin
            if (ftw_valid) begin
                if (m_ftw == 0) m_ftw = ftw_in;
                else begin
                    m_pend = ftw_in;
                    m_mode = M_PEND;
                end
            end else if (sweep_en && m_ftw < sweep_stop) begin
                m_mode = M_SWEEP;
            end
        end else if (m_mode == M_PEND) begin
            if (w) begin
                m_ftw = m_pend;
                m_mode = M_RUN;
            end
        end else begin
            if (!sweep_en) m_mode = M_RUN;
            else if (w) begin
                t = m_ftw + sweep_step;
                if (t >= sweep_stop) begin
                    m_ftw = sweep_stop;
                    m_done = 1;
                    m_mode = M_RUN;
                end else m_ftw = t;
            end
        end
        m_acc = a;
        m_ready = (m_mode == M_RUN);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h",
                      name, act, exp);
    endtask

    typedef struct {
        bit          rst;
        bit          en;
        logic [31:0] ftw;
        bit          valid;
        logic [11:0] off;
        logic [11:0] ph;
        bit          wr;
        bit          rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit en, logic [31:0] f,
                                bit v, logic [11:0] o,
                                logic [11:0] ph, bit wr, bit rdy);
        vec_t x;
        x.rst = r; x.en = en; x.ftw = f; x.valid = v; x.off = o;
        x.ph = ph; x.wr = wr; x.rdy = rdy;
        return x;
    endfunction

    int done_cyc;
    int first_wrap;
    int wraps;
    int wraps_at_done;
    int dones;
    logic [11:0] ph_at_done;
    logic rdy_mid;
    logic [11:0] ph_hold;
    int bad_hold;

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1; enable = 0; ftw_in = 0; ftw_valid = 0;
        phase_off = 0; sweep_en = 0; sweep_step = 0; sweep_stop = 0;

        // reset, offset with FTW=0, immediate load, pend to wrap
        vecs.push_back(mk(1, 1, 32'h1000_0000, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 32'h1000_0000, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 12'd4095, 12'd4095, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 12'd1, 12'd1, 0, 1));
        vecs.push_back(mk(0, 1, 32'h1000_0000, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 12'd256, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 12'd512, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 12'd16, 12'd784, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 12'd768, 0, 1));
        vecs.push_back(mk(0, 1, 32'h2000_0000, 1, 0, 12'd1024, 0, 0));
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFF, 1, 0, 12'd1280, 0, 0));
        for (int k = 6; k < 16; k++)
            vecs.push_back(mk(0, 1, 0, 0, 0, 12'(k * 256), 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 12'd512, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 12'd1024, 0, 1));

        foreach (vecs[i]) begin
            rst = vecs[i].rst; enable = vecs[i].en;
            ftw_in = vecs[i].ftw; ftw_valid = vecs[i].valid;
            phase_off = vecs[i].off;
            tick();
            check($sformatf("tbl%0d_phase", i), 32'(phase_out),
                  32'(vecs[i].ph));
            check($sformatf("tbl%0d_wrap", i), 32'(wrap_pulse),
                  32'(vecs[i].wr));
            check($sformatf("tbl%0d_ready", i), 32'(ftw_ready),
                  32'(vecs[i].rdy));
            check($sformatf("tbl%0d_done", i), 32'(sweep_done), 0);
        end

        // sweep 0x0800_0000 -> 0x0801_0000 in steps of 0x8000
        rst = 1; ftw_valid = 0; phase_off = 0; tick();
        rst = 0; enable = 1; ftw_in = 32'h0800_0000; ftw_valid = 1;
        sweep_en = 1; sweep_step = 16'h8000;
        sweep_stop = 32'h0801_0000;
        tick();
        ftw_valid = 0;
        done_cyc = -1; first_wrap = -1; wraps = 0; dones = 0;
        wraps_at_done = 0; ph_at_done = 0; rdy_mid = 1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (wrap_pulse) begin
                wraps++;
                if (first_wrap < 0) first_wrap = c;
            end
            if (sweep_done) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    wraps_at_done = wraps;
                    ph_at_done = phase_out;
                end
            end
            if (c == 10) rdy_mid = ftw_ready;
        end
        check("sw_first_wrap", first_wrap, 32);
        check("sw_done_cycle", done_cyc, 64);
        check("sw_wraps_at_done", wraps_at_done, 2);
        check("sw_done_count", dones, 1);
        check("sw_phase_at_done", 32'(ph_at_done), 1);
        check("sw_ready_mid", 32'(rdy_mid), 0);
        check("sw_ready_end", 32'(ftw_ready), 1);
        sweep_en = 0;

        // handshake beats sweep entry, then pause inside S_PEND
        rst = 1; tick();
        rst = 0; enable = 1; ftw_in = 32'h4000_0000; ftw_valid = 1;
        tick();
        ftw_in = 32'h1000_0000; sweep_en = 1;
        sweep_stop = 32'hF000_0000; sweep_step = 16'h1000;
        tick();
        check("b_pend_ready", 32'(ftw_ready), 0);
        check("b_pend_phase", 32'(phase_out), 1024);
        ftw_valid = 0; sweep_en = 0; enable = 0;
        bad_hold = 0; ph_hold = phase_out;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (phase_out !== ph_hold || wrap_pulse !== 1'b0
                || ftw_ready !== 1'b0)
                bad_hold++;
        end
        check("b_pause_frozen", bad_hold, 0);
        enable = 1;
        tick(); tick();
        check("b_pre_wrap_phase", 32'(phase_out), 3072);
        check("b_pre_wrap_ready", 32'(ftw_ready), 0);
        tick();
        check("b_wrap_pulse", 32'(wrap_pulse), 1);
        check("b_wrap_ready", 32'(ftw_ready), 1);
        tick();
        check("b_new_ftw_phase", 32'(phase_out), 256);

        // reset in the middle of a sweep
        sweep_en = 1;
        tick();
        check("b_sweep_ready", 32'(ftw_ready), 0);
        for (int c = 0; c < 5; c++) tick();
        rst = 1; tick();
        check("b_rst_done", 32'(sweep_done), 0);
        check("b_rst_phase", 32'(phase_out), 0);
        check("b_rst_ready", 32'(ftw_ready), 1);
        rst = 0; sweep_en = 0;
        for (int c = 0; c < 5; c++) tick();
        check("b_rst_ftw_zero", 32'(phase_out), 0);
        check("b_rst_no_wrap", 32'(wrap_pulse), 0);

        // randomized run against the model
        rst = 1; tick();
        rst = 0;
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 9) != 0);
            ftw_valid = ($urandom_range(0, 7) == 0);
            ftw_in = $urandom;
            if ($urandom_range(0, 15) == 0) ftw_in = 32'h0;
            phase_off = 12'($urandom);
            if ($urandom_range(0, 15) == 0) sweep_en = ~sweep_en;
            if ($urandom_range(0, 15) == 0) begin
                sweep_step = 16'($urandom);
                sweep_stop = 32'(m_ftw
                    + longint'($urandom_range(0, 32'h40000)));
            end
            tick();
            check("rnd_phase", 32'(phase_out), 32'(m_phase));
            check("rnd_wrap", 32'(wrap_pulse), 32'(m_wrap));
            check("rnd_ready", 32'(ftw_ready), 32'(m_ready));
            check("rnd_done", 32'(sweep_done), 32'(m_done));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
